seven_segment_scan_reader: RTL and testbench

Receive-side counterpart of the BCD-to-seven-segment decoder: samples a multiplexed seven-segment bus (segment lines plus one-hot digit strobes) and reconstructs the displayed digits as packed 4-bit codes. A segment pattern is accepted only after it has been stable for a programmable number of cycles. Each completed frame is delivered through a valid/ready handshake. The block sits between a display-bus sniffer, or a loopback of the display driver, and downstream checking or logging logic.

---
 rtl/seg7_pkg.sv | 31 +++
 rtl/seg_glyph_decode.sv | 37 +++
 rtl/seven_segment_scan_reader.sv | 116 +++++++++++
 tb/tb_seven_segment_scan_reader.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants, glyph patterns and FSM state type for the seven-segment scan reader.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned NIB_W = 4;

  // Segment order: bit6=a .. bit0=g, active-high.
  localparam logic [SEG_W-1:0] GLYPH_0 = 7'h7E;
  localparam logic [SEG_W-1:0] GLYPH_1 = 7'h30;
  localparam logic [SEG_W-1:0] GLYPH_2 = 7'h6D;
  localparam logic [SEG_W-1:0] GLYPH_3 = 7'h79;
  localparam logic [SEG_W-1:0] GLYPH_4 = 7'h33;
  localparam logic [SEG_W-1:0] GLYPH_5 = 7'h5B;
  localparam logic [SEG_W-1:0] GLYPH_6 = 7'h5F;
  localparam logic [SEG_W-1:0] GLYPH_7 = 7'h70;
  localparam logic [SEG_W-1:0] GLYPH_8 = 7'h7F;
  localparam logic [SEG_W-1:0] GLYPH_9 = 7'h7B;
  localparam logic [SEG_W-1:0] GLYPH_A = 7'h77;
  localparam logic [SEG_W-1:0] GLYPH_B = 7'h1F;
  localparam logic [SEG_W-1:0] GLYPH_C = 7'h4E;
  localparam logic [SEG_W-1:0] GLYPH_D = 7'h3D;
  localparam logic [SEG_W-1:0] GLYPH_E = 7'h4F;
  localparam logic [SEG_W-1:0] GLYPH_F = 7'h47;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACK,
    ST_HELD
  } scan_state_t;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational seven-segment pattern to nibble decoder.
// Hex letters A-F are recognised only when SEG_SCAN_HEX_EN is defined.
module seg_glyph_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] i_seg,
  output logic [NIB_W-1:0] o_nib,
  output logic             o_valid
);

  always_comb begin
    o_nib   = '0;
    o_valid = 1'b1;
    case (i_seg)
      GLYPH_0: o_nib = 4'h0;
      GLYPH_1: o_nib = 4'h1;
      GLYPH_2: o_nib = 4'h2;
      GLYPH_3: o_nib = 4'h3;
      GLYPH_4: o_nib = 4'h4;
      GLYPH_5: o_nib = 4'h5;
      GLYPH_6: o_nib = 4'h6;
      GLYPH_7: o_nib = 4'h7;
      GLYPH_8: o_nib = 4'h8;
      GLYPH_9: o_nib = 4'h9;
`ifdef SEG_SCAN_HEX_EN
      GLYPH_A: o_nib = 4'hA;
      GLYPH_B: o_nib = 4'hB;
      GLYPH_C: o_nib = 4'hC;
      GLYPH_D: o_nib = 4'hD;
      GLYPH_E: o_nib = 4'hE;
      GLYPH_F: o_nib = 4'hF;
`endif
      default: o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_segment_scan_reader.sv
// Reconstructs digits from a multiplexed seven-segment bus with a stability filter
// and delivers whole frames over valid/ready. Optional hex decode: SEG_SCAN_HEX_EN.
module seven_segment_scan_reader
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEG_W-1:0]      seg_in,
  input  logic [DIGITS-1:0]     dig_in,
  output logic [4*DIGITS-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  glyph_err
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SEG_W-1:0]    r_seg, r_prev_seg;
  logic [DIGITS-1:0]   r_dig, r_prev_dig;
  logic [CNT_W-1:0]    r_cnt;
  logic [4*DIGITS-1:0] r_slots;
  scan_state_t         r_state;

  scan_state_t         w_state_next;
  logic [CNT_W-1:0]    w_cnt_next;
  logic                w_commit;
  logic                w_onehot;
  logic                w_change;
  logic [NIB_W-1:0]    w_nib;
  logic                w_glyph_ok;
  logic [DIGITS-1:0]   w_commit_mask;
  logic                w_load;

  seg_glyph_decode u_decode (
    .i_seg   (r_seg),
    .o_nib   (w_nib),
    .o_valid (w_glyph_ok)
  );

  assign w_onehot = $onehot(r_dig);
  assign w_change = (r_seg != r_prev_seg) || (r_dig != r_prev_dig);

  // A commit fires on the single transition of the run counter into CNT_MAX,
  // so a pattern held indefinitely in HELD never commits again.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_commit     = 1'b0;
    if (!w_onehot) begin
      w_state_next = ST_IDLE;
      w_cnt_next   = '0;
    end else if (w_change) begin
      w_cnt_next   = CNT_ONE;
      w_commit     = (CNT_ONE == CNT_MAX);
      w_state_next = w_commit ? ST_HELD : ST_TRACK;
    end else if (r_cnt != CNT_MAX) begin
      w_cnt_next   = r_cnt + CNT_ONE;
      w_commit     = (w_cnt_next == CNT_MAX);
      w_state_next = w_commit ? ST_HELD : ST_TRACK;
    end else begin
      w_state_next = ST_HELD;
    end
  end

  assign w_commit_mask = (w_commit && w_glyph_ok) ? r_dig : '0;
  assign w_load        = (&digit_valid) && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg       <= '0;
      r_dig       <= '0;
      r_prev_seg  <= '0;
      r_prev_dig  <= '0;
      r_cnt       <= '0;
      r_slots     <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      digit_valid <= '0;
      glyph_err   <= 1'b0;
    end else begin
      r_seg      <= seg_in;
      r_dig      <= dig_in;
      r_prev_seg <= r_seg;
      r_prev_dig <= r_dig;
      r_cnt      <= w_cnt_next;
      glyph_err  <= w_commit && !w_glyph_ok;
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (w_commit_mask[i]) r_slots[4*i +: 4] <= w_nib;
      end
      // The snapshot takes the pre-commit slots; a same-cycle commit starts the next frame.
      if (w_load) begin
        out_data    <= r_slots;
        out_valid   <= 1'b1;
        digit_valid <= w_commit_mask;
      end else begin
        if (out_ready) out_valid <= 1'b0;
        digit_valid <= digit_valid | w_commit_mask;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_reader.sv
// Scoreboard bench for seven_segment_scan_reader (DIGITS=4, STABLE_CYCLES=3).
module tb_seven_segment_scan_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_in;
  logic [3:0]  dig_in;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  digit_valid;
  logic        glyph_err;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] frame_q[$];
  int          err_q[$];

  seven_segment_scan_reader #(.DIGITS(4), .STABLE_CYCLES(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .dig_in      (dig_in),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .digit_valid (digit_valid),
    .glyph_err   (glyph_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic show(input logic [3:0] d, input logic [6:0] s, input int n);
    dig_in = d;
    seg_in = s;
    repeat (n) cyc();
  endtask

  task automatic blank();
    dig_in = '0;
    seg_in = '0;
    cyc();
  endtask

  task automatic digit(input logic [3:0] d, input logic [6:0] s);
    show(d, s, 3);
    blank();
  endtask

  // Monitor: compares each accepted frame and each glyph_err cycle against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        vectors++;
        if (frame_q.size() == 0) begin
          miscompares++;
          $display("FAIL frame_unexpected: got %0h expected none", out_data);
        end else begin
          logic [15:0] exp;
          exp = frame_q.pop_front();
          if (out_data !== exp) begin
            miscompares++;
            $display("FAIL frame_data: got %0h expected %0h", out_data, exp);
          end
        end
      end
      if (!rst && glyph_err) begin
        vectors++;
        if (err_q.size() == 0) begin
          miscompares++;
          $display("FAIL glyph_err_unexpected: got 1 expected 0");
        end else begin
          void'(err_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; out_ready = 1'b1; seg_in = '0; dig_in = '0;
    repeat (3) cyc();
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_digit_valid", 32'(digit_valid), 32'h0);
    check("rst_glyph_err", 32'(glyph_err), 32'h0);
    rst = 1'b0;
    cyc();

    // Reset mid-frame: slots 0,1 hold 9,8 and must be discarded.
    digit(4'b0001, 7'h7B);
    digit(4'b0010, 7'h7F);
    check("partial_dv", 32'(digit_valid), 32'h3);
    rst = 1'b1;
    cyc(); cyc();
    check("midrst_dv", 32'(digit_valid), 32'h0);
    check("midrst_valid", 32'(out_valid), 32'h0);
    check("midrst_data", 32'(out_data), 32'h0);
    rst = 1'b0;
    cyc();
    frame_q.push_back(16'h3210);
    digit(4'b0100, 7'h6D);
    digit(4'b1000, 7'h79);
    digit(4'b0001, 7'h7E);
    digit(4'b0010, 7'h30);
    repeat (3) blank();

    // Basic frame with commit/load timing.
    frame_q.push_back(16'h3210);
    digit(4'b0001, 7'h7E);
    digit(4'b0010, 7'h30);
    digit(4'b0100, 7'h6D);
    show(4'b1000, 7'h79, 3);
    blank();
    check("basic_dv_full", 32'(digit_valid), 32'hF);
    check("basic_valid_early", 32'(out_valid), 32'h0);
    blank();
    check("basic_valid", 32'(out_valid), 32'h1);
    check("basic_dv_clear", 32'(digit_valid), 32'h0);
    blank();
    check("basic_valid_drop", 32'(out_valid), 32'h0);

    // Glitch filter and a long hold on the frame-completing digit.
    frame_q.push_back(16'h4321);
    digit(4'b0010, 7'h6D);
    digit(4'b0100, 7'h79);
    digit(4'b1000, 7'h33);
    show(4'b0001, 7'h7E, 2);
    show(4'b0001, 7'h30, 53);
    blank();
    check("hold_single_commit", 32'(digit_valid), 32'h0);
    repeat (2) blank();

    // Invalid glyphs.
    err_q.push_back(1);
    digit(4'b0100, 7'h00);
    check("blank_glyph_dv", 32'(digit_valid), 32'h0);
`ifdef SEG_SCAN_HEX_EN
    digit(4'b0100, 7'h77);
    check("hex_a_dv", 32'(digit_valid), 32'h4);
    frame_q.push_back(16'h3A10);
    digit(4'b0001, 7'h7E);
    digit(4'b0010, 7'h30);
    digit(4'b1000, 7'h79);
    repeat (3) blank();
`else
    err_q.push_back(2);
    digit(4'b0100, 7'h77);
    check("hex_a_dv", 32'(digit_valid), 32'h0);
`endif

    // Backpressure across two frames.
    out_ready = 1'b0;
    frame_q.push_back(16'h3210);
    frame_q.push_back(16'h7654);
    digit(4'b0001, 7'h7E);
    digit(4'b0010, 7'h30);
    digit(4'b0100, 7'h6D);
    digit(4'b1000, 7'h79);
    repeat (2) blank();
    digit(4'b0001, 7'h33);
    digit(4'b0010, 7'h5B);
    digit(4'b0100, 7'h5F);
    digit(4'b1000, 7'h70);
    repeat (2) blank();
    check("bp_valid", 32'(out_valid), 32'h1);
    check("bp_hold_data", 32'(out_data), 32'h3210);
    check("bp_dv_full", 32'(digit_valid), 32'hF);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("b2b_valid", 32'(out_valid), 32'h1);
    check("b2b_data", 32'(out_data), 32'h7654);
    check("b2b_dv_clear", 32'(digit_valid), 32'h0);
    out_ready = 1'b1;
    cyc(); cyc();
    check("b2b_drained", 32'(out_valid), 32'h0);

    // Multi-hot strobes are ignored.
    digit(4'b0001, 7'h7E);
    check("mh_pre_dv", 32'(digit_valid), 32'h1);
    show(4'b0011, 7'h30, 10);
    repeat (2) blank();
    check("mh_dv", 32'(digit_valid), 32'h1);

    repeat (5) blank();
    check("frames_pending", 32'(frame_q.size()), 32'h0);
    check("errs_pending", 32'(err_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
